// File: rtl/forward_hazard_ctrl.sv
// Hazard controller for the 5-stage core: EXE/MEM destination trackers, registered forwarding selects,
// load-use stall, mem_wait freeze and branch flush. Define HAZARD_PERF_CNT_EN to add saturating perf counters.
module forward_hazard_ctrl #(
   parameter int REG_ADDR_SIZE = 5,
   parameter int CNT_SIZE      = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     id_valid,
   input  logic [REG_ADDR_SIZE-1:0] id_rs1_addr,
   input  logic [REG_ADDR_SIZE-1:0] id_rs2_addr,
   input  logic                     id_rs1_used,
   input  logic                     id_rs2_used,
   input  logic [REG_ADDR_SIZE-1:0] id_rd_addr,
   input  logic                     id_reg_write,
   input  logic                     id_mem_read,
   input  logic                     exe_branch_taken,
   input  logic                     mem_wait,
   output logic                     rs1_exe_hazard,
   output logic                     rs1_mem_hazard,
   output logic                     rs2_exe_hazard,
   output logic                     rs2_mem_hazard,
   output logic                     stall,
   output logic                     id_exe_bubble,
   output logic                     if_id_flush
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_SIZE-1:0]      stall_cnt,
   output logic [CNT_SIZE-1:0]      fwd_cnt,
   output logic [CNT_SIZE-1:0]      flush_cnt
`endif
);

   localparam logic RUN      = 1'b0;
   localparam logic LU_STALL = 1'b1;

   logic                     state_reg, state_next;
   logic                     exe_valid_reg, exe_we_reg, exe_ld_reg;
   logic [REG_ADDR_SIZE-1:0] exe_rd_reg;
   logic                     mem_valid_reg, mem_we_reg;
   logic [REG_ADDR_SIZE-1:0] mem_rd_reg;
   logic [1:0]               sel_exe_reg, sel_mem_reg;

   logic [REG_ADDR_SIZE-1:0] rs_addr [2];
   logic [1:0]               rs_used;
   logic [1:0]               match_exe, match_mem;
   logic                     load_use, advance, kill;
   logic                     stall_c, bubble_c, flush_c;

   assign rs_addr[0] = id_rs1_addr;
   assign rs_addr[1] = id_rs2_addr;
   assign rs_used    = {id_rs2_used, id_rs1_used};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_match
         assign match_exe[gi] = exe_valid_reg & exe_we_reg & (exe_rd_reg != '0) &
                                (rs_addr[gi] == exe_rd_reg) & rs_used[gi];
         assign match_mem[gi] = mem_valid_reg & mem_we_reg & (mem_rd_reg != '0) &
                                (rs_addr[gi] == mem_rd_reg) & rs_used[gi];
      end
   endgenerate

   // In LU_STALL the EXE slot holds the inserted bubble, so a fresh load-use can only start from RUN.
   assign load_use = id_valid & exe_ld_reg & (|match_exe) & (state_reg == RUN);

   always_comb begin
      stall_c    = 1'b0;
      bubble_c   = 1'b0;
      flush_c    = 1'b0;
      advance    = 1'b0;
      state_next = state_reg;
      if (!rst) begin
         if (mem_wait) begin
            stall_c = 1'b1;
         end else if (exe_branch_taken) begin
            flush_c    = 1'b1;
            bubble_c   = 1'b1;
            advance    = 1'b1;
            state_next = RUN;
         end else if (load_use) begin
            stall_c    = 1'b1;
            bubble_c   = 1'b1;
            advance    = 1'b1;
            state_next = LU_STALL;
         end else begin
            advance    = 1'b1;
            state_next = RUN;
         end
      end
   end

   assign kill = bubble_c | ~id_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= RUN;
         exe_valid_reg <= 1'b0;
         exe_we_reg    <= 1'b0;
         exe_ld_reg    <= 1'b0;
         exe_rd_reg    <= '0;
         mem_valid_reg <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_rd_reg    <= '0;
         sel_exe_reg   <= '0;
         sel_mem_reg   <= '0;
      end else if (advance) begin
         state_reg     <= state_next;
         mem_valid_reg <= exe_valid_reg;
         mem_we_reg    <= exe_we_reg;
         mem_rd_reg    <= exe_rd_reg;
         exe_valid_reg <= ~kill;
         exe_we_reg    <= id_reg_write & ~kill;
         exe_ld_reg    <= id_mem_read & ~kill;
         exe_rd_reg    <= kill ? '0 : id_rd_addr;
         // Newest producer wins: a MEM match is dropped when EXE also writes that register.
         sel_exe_reg   <= kill ? 2'b00 : match_exe;
         sel_mem_reg   <= kill ? 2'b00 : (match_mem & ~match_exe);
      end
   end

   assign rs1_exe_hazard = sel_exe_reg[0];
   assign rs2_exe_hazard = sel_exe_reg[1];
   assign rs1_mem_hazard = sel_mem_reg[0];
   assign rs2_mem_hazard = sel_mem_reg[1];
   assign stall          = stall_c;
   assign id_exe_bubble  = bubble_c;
   assign if_id_flush    = flush_c;

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [CNT_SIZE-1:0] CNT_ONE = {{(CNT_SIZE-1){1'b0}}, 1'b1};

   logic lu_stall_evt, fwd_evt;
   assign lu_stall_evt = advance & (state_next == LU_STALL);
   assign fwd_evt      = advance & ~kill & ((|match_exe) | (|match_mem));

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         fwd_cnt   <= '0;
         flush_cnt <= '0;
      end else begin
         if (lu_stall_evt && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_ONE;
         if (fwd_evt && fwd_cnt != '1)        fwd_cnt   <= fwd_cnt + CNT_ONE;
         if (flush_c && flush_cnt != '1)      flush_cnt <= flush_cnt + CNT_ONE;
      end
   end
`endif

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Self-checking bench for forward_hazard_ctrl: directed scenarios plus randomized traffic
// compared against an instruction-level pipeline model.
module tb_forward_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic       id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
   logic       exe_branch_taken, mem_wait;
   logic       rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard;
   logic       stall, id_exe_bubble, if_id_flush;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt, fwd_cnt, flush_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   forward_hazard_ctrl #(.REG_ADDR_SIZE(5), .CNT_SIZE(32)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd_addr(id_rd_addr),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .exe_branch_taken(exe_branch_taken), .mem_wait(mem_wait),
      .rs1_exe_hazard(rs1_exe_hazard), .rs1_mem_hazard(rs1_mem_hazard),
      .rs2_exe_hazard(rs2_exe_hazard), .rs2_mem_hazard(rs2_mem_hazard),
      .stall(stall), .id_exe_bubble(id_exe_bubble), .if_id_flush(if_id_flush)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt), .flush_cnt(flush_cnt)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(input logic v, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2,
                           input logic [4:0] rd, input logic we, input logic ld);
      id_valid = v;  id_rs1_addr = rs1; id_rs1_used = u1;
      id_rs2_addr = rs2; id_rs2_used = u2;
      id_rd_addr = rd; id_reg_write = we; id_mem_read = ld;
   endtask

   task automatic drain();
      drive_id(0, 0, 0, 0, 0, 0, 0, 0);
      exe_branch_taken = 0; mem_wait = 0;
      tick(); tick();
   endtask

   task automatic test_reset();
      rst = 1; mem_wait = 1; exe_branch_taken = 1;
      drive_id(1, 5, 1, 6, 1, 7, 1, 1);
      @(negedge clk);
      checks++;
      if ({stall, id_exe_bubble, if_id_flush} !== 3'b000) begin
         errors++;
         $display("FAIL reset_comb got=%b want=000", {stall, id_exe_bubble, if_id_flush});
      end
      tick();
      checks++;
      if ({rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_sel got=%b want=0000",
                  {rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard});
      end
      rst = 0; mem_wait = 0; exe_branch_taken = 0;
      drain();
   endtask

   task automatic test_exe_fwd();
      drive_id(1, 1, 1, 2, 1, 5, 1, 0);           // add x5
      tick();
      drive_id(1, 5, 1, 1, 1, 6, 1, 0);           // add x6,x5,x1
      @(negedge clk);
      checks++;
      if (stall !== 1'b0) begin
         errors++; $display("FAIL exe_fwd_nostall got=%b want=0", stall);
      end
      tick();
      checks++;
      if ({rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard} !== 4'b1000) begin
         errors++;
         $display("FAIL exe_fwd_sel got=%b want=1000",
                  {rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard});
      end
      drain();
   endtask

   task automatic test_mem_fwd();
      drive_id(1, 1, 1, 2, 1, 5, 1, 0); tick();   // writes x5
      drive_id(1, 2, 1, 3, 1, 9, 1, 0); tick();   // unrelated
      drive_id(1, 5, 1, 4, 1, 6, 1, 0); tick();   // reads x5
      checks++;
      if ({rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard} !== 4'b0100) begin
         errors++;
         $display("FAIL mem_fwd_sel got=%b want=0100",
                  {rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard});
      end
      drain();
      drive_id(1, 1, 1, 2, 1, 5, 1, 0); tick();   // writes x5
      drive_id(1, 1, 1, 2, 1, 5, 1, 0); tick();   // writes x5 again
      drive_id(1, 3, 1, 5, 1, 6, 1, 0); tick();   // reads x5 on rs2
      checks++;
      if ({rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard} !== 4'b0010) begin
         errors++;
         $display("FAIL newest_wins got=%b want=0010",
                  {rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard});
      end
      drain();
   endtask

   task automatic test_load_use();
      drive_id(1, 1, 1, 0, 0, 7, 1, 1); tick();   // lw x7
      drive_id(1, 7, 1, 7, 1, 8, 1, 0);           // add x8,x7,x7
      @(negedge clk);
      checks++;
      if ({stall, id_exe_bubble, if_id_flush} !== 3'b110) begin
         errors++; $display("FAIL lu_stall got=%b want=110", {stall, id_exe_bubble, if_id_flush});
      end
      tick();
      @(negedge clk);
      checks++;
      if ({stall, id_exe_bubble, if_id_flush} !== 3'b000) begin
         errors++; $display("FAIL lu_release got=%b want=000", {stall, id_exe_bubble, if_id_flush});
      end
      tick();
      checks++;
      if ({rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard} !== 4'b0101) begin
         errors++;
         $display("FAIL lu_sel got=%b want=0101",
                  {rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard});
      end
      drain();
   endtask

   task automatic test_x0();
      drive_id(1, 1, 1, 2, 1, 0, 1, 0); tick();   // writes x0
      drive_id(1, 0, 1, 0, 1, 4, 1, 0); tick();   // reads x0
      checks++;
      if ({rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard} !== 4'b0000) begin
         errors++;
         $display("FAIL x0_sel got=%b want=0000",
                  {rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard});
      end
      drain();
   endtask

   task automatic test_mem_wait_freeze();
      drive_id(1, 1, 1, 0, 0, 7, 1, 1); tick();   // lw x7
      drive_id(1, 7, 1, 7, 1, 8, 1, 0); tick();   // enters load-use stall
      mem_wait = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({stall, id_exe_bubble, if_id_flush, rs1_mem_hazard, rs2_mem_hazard} !== 5'b10000) begin
            errors++;
            $display("FAIL freeze_lu[%0d] got=%b want=10000", i,
                     {stall, id_exe_bubble, if_id_flush, rs1_mem_hazard, rs2_mem_hazard});
         end
         tick();
      end
      mem_wait = 0;
      @(negedge clk);
      checks++;
      if ({stall, id_exe_bubble} !== 2'b00) begin
         errors++; $display("FAIL freeze_resume got=%b want=00", {stall, id_exe_bubble});
      end
      tick();
      checks++;
      if ({rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard} !== 4'b0101) begin
         errors++;
         $display("FAIL freeze_sel got=%b want=0101",
                  {rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard});
      end
      mem_wait = 1;
      drive_id(1, 2, 1, 3, 1, 4, 1, 0);
      tick(); tick();
      checks++;
      if ({rs1_mem_hazard, rs2_mem_hazard} !== 2'b11) begin
         errors++; $display("FAIL freeze_hold_sel got=%b want=11", {rs1_mem_hazard, rs2_mem_hazard});
      end
      drain();
   endtask

   task automatic test_flush_lu();
      drive_id(1, 1, 1, 0, 0, 7, 1, 1); tick();   // lw x7
      drive_id(1, 7, 1, 0, 0, 8, 1, 0);
      exe_branch_taken = 1;
      @(negedge clk);
      checks++;
      if ({stall, id_exe_bubble, if_id_flush} !== 3'b011) begin
         errors++; $display("FAIL flush_over_lu got=%b want=011", {stall, id_exe_bubble, if_id_flush});
      end
      tick();
      exe_branch_taken = 0;
      checks++;
      if ({rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard} !== 4'b0000) begin
         errors++;
         $display("FAIL flush_sel got=%b want=0000",
                  {rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard});
      end
      drive_id(1, 7, 1, 0, 0, 9, 1, 0);           // load now in MEM: forward, no stall
      @(negedge clk);
      checks++;
      if (stall !== 1'b0) begin
         errors++; $display("FAIL after_flush_stall got=%b want=0", stall);
      end
      tick();
      checks++;
      if (rs1_mem_hazard !== 1'b1) begin
         errors++; $display("FAIL after_flush_fwd got=%b want=1", rs1_mem_hazard);
      end
      drain();
   endtask

   task automatic test_rst_mid_stall();
      drive_id(1, 1, 1, 0, 0, 7, 1, 1); tick();
      drive_id(1, 7, 1, 0, 0, 8, 1, 0); tick();   // now in LU_STALL
      rst = 1;
      @(negedge clk);
      checks++;
      if ({stall, id_exe_bubble, if_id_flush} !== 3'b000) begin
         errors++; $display("FAIL rst_mid_comb got=%b want=000", {stall, id_exe_bubble, if_id_flush});
      end
      tick();
      rst = 0;
      checks++;
      if ({rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard, stall} !== 5'b00000) begin
         errors++;
         $display("FAIL rst_mid_after got=%b want=00000",
                  {rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard, stall});
      end
      tick();
      checks++;
      if (rs1_mem_hazard !== 1'b0) begin
         errors++; $display("FAIL rst_cleared_trackers got=%b want=0", rs1_mem_hazard);
      end
      drain();
   endtask

   typedef struct packed {
      bit       v;
      bit [4:0] rd;
      bit       we;
      bit       ld;
   } ins_t;

   function automatic bit produces(ins_t p, bit [4:0] rs, bit used);
      return p.v && p.we && p.rd != 0 && rs == p.rd && used;
   endfunction

   task automatic test_random();
      ins_t     in_exe, in_mem, incoming;
      bit [3:0] sel;        // {rs1_exe, rs1_mem, rs2_exe, rs2_mem}
      bit [6:0] want, got;
      bit       lu, h1e, h1m, h2e, h2m;
      rst = 1; drive_id(0, 0, 0, 0, 0, 0, 0, 0); tick();
      rst = 0;
      in_exe = '0; in_mem = '0; sel = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         rst              = ($urandom_range(0, 49) == 0);
         mem_wait         = ($urandom_range(0, 5) == 0);
         exe_branch_taken = ($urandom_range(0, 7) == 0);
         drive_id($urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
         h1e = produces(in_exe, id_rs1_addr, id_rs1_used);
         h2e = produces(in_exe, id_rs2_addr, id_rs2_used);
         h1m = produces(in_mem, id_rs1_addr, id_rs1_used);
         h2m = produces(in_mem, id_rs2_addr, id_rs2_used);
         lu  = id_valid && in_exe.ld && (h1e || h2e);
         want = {sel, 3'b000};
         if (!rst) begin
            if (mem_wait)              want[2:0] = 3'b100;
            else if (exe_branch_taken) want[2:0] = 3'b011;
            else if (lu)               want[2:0] = 3'b110;
         end
         @(negedge clk);
         got = {rs1_exe_hazard, rs1_mem_hazard, rs2_exe_hazard, rs2_mem_hazard,
                stall, id_exe_bubble, if_id_flush};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL random[%0d] sel/stall/bubble/flush got=%b want=%b", cyc, got, want);
         end
         @(posedge clk);
         if (rst) begin
            in_exe = '0; in_mem = '0; sel = '0;
         end else if (!mem_wait) begin
            if (exe_branch_taken || lu || !id_valid) begin
               sel = '0;
               incoming = '0;
            end else begin
               sel = {h1e, h1m && !h1e, h2e, h2m && !h2e};
               incoming = '{v: 1'b1, rd: id_rd_addr, we: id_reg_write, ld: id_mem_read};
            end
            in_mem = in_exe;
            in_exe = incoming;
         end
         #1;
      end
      rst = 0;
      drain();
   endtask

   initial begin
      rst = 1; mem_wait = 0; exe_branch_taken = 0;
      drive_id(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      test_reset();
      test_exe_fwd();
      test_mem_fwd();
      test_load_use();
      test_x0();
      test_mem_wait_freeze();
      test_flush_lu();
      test_rst_mid_stall();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
